// File: rtl/ram.sv
`default_nettype none
// ============================================================================
//  Module   : ram
//  Brief    : 2^ADDR_W x DATA_W byte memory with a registered big-endian
//             two-byte read port and asynchronous active-low clear.
//  Revision : 1.0  initial release
// ============================================================================
module ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rw,
    input  logic [ADDR_W-1:0]     adrs,
    input  logic [DATA_W-1:0]     din,
    output logic [2*DATA_W-1:0]   dout
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0]   mem_q [c_depth];
    logic [DATA_W-1:0]   mem_d [c_depth];
    logic [2*DATA_W-1:0] dout_q;
    logic [2*DATA_W-1:0] dout_d;
    logic [ADDR_W-1:0]   adrs_nxt;

    // Second byte address wraps naturally at the ADDR_W boundary.
    assign adrs_nxt = adrs + ADDR_W'(1);

    always_comb begin
        mem_d  = mem_q;
        dout_d = dout_q;
        if (rw) begin
            mem_d[adrs] = din;
        end else begin
            dout_d = {mem_q[adrs], mem_q[adrs_nxt]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            for (int i = 0; i < c_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram
//  Brief    : Scoreboard testbench for ram; reference memory model predicts
//             dout after every clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic                clk;
    logic                rst_n;
    logic                rw;
    logic [ADDR_W-1:0]   adrs;
    logic [DATA_W-1:0]   din;
    logic [2*DATA_W-1:0] dout;

    logic [DATA_W-1:0]   m_mem [256];
    logic [2*DATA_W-1:0] m_dout;
    logic [2*DATA_W-1:0] exp_q [$];

    int n_cmp;
    int n_err;

    ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rw    (rw),
        .adrs  (adrs),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: dout=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_dout = 16'h0000;
    endtask

    // One clocked operation: drive at negedge, predict, check after posedge.
    task automatic op(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] a1;
        @(negedge clk);
        rw   = w;
        adrs = a;
        din  = d;
        if (rst_n) begin
            a1 = a + 8'd1;
            if (w) m_mem[a] = d;
            else   m_dout = {m_mem[a], m_mem[a1]};
        end
        exp_q.push_back(m_dout);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            chk(tag, dout, exp_q.pop_front());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        rw    = 1'b0;
        adrs  = '0;
        din   = '0;
        model_clear();
        #1;
        chk("reset_dout", dout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Reads of a freshly cleared memory
        op("rd00", 1'b0, 8'h00, 8'h00);
        op("rd01", 1'b0, 8'h01, 8'h00);
        op("rd03", 1'b0, 8'h03, 8'h00);

        // Single-byte write and big-endian placement
        op("wr03", 1'b1, 8'h03, 8'hFF);
        op("rd03_ff", 1'b0, 8'h03, 8'h00);
        op("rd02_ff", 1'b0, 8'h02, 8'h00);

        // Wrap-around
        op("wrFF", 1'b1, 8'hFF, 8'hAB);
        op("wr00", 1'b1, 8'h00, 8'hCD);
        op("rdFF_wrap", 1'b0, 8'hFF, 8'h00);

        // dout holds across a run of writes
        op("rd10", 1'b0, 8'h10, 8'h00);
        for (int i = 0; i < 4; i++) op("hold_wr10", 1'b1, 8'h10, 8'h5A);
        op("rd10_5a", 1'b0, 8'h10, 8'h00);

        // Inputs changing between edges have no effect
        for (int i = 0; i < 3; i++) begin
            #1;
            rw   = ~rw;
            adrs = adrs ^ 8'h5F;
            din  = din + 8'h33;
            chk("toggle_hold", dout, m_dout);
        end
        op("rd10_after_toggle", 1'b0, 8'h10, 8'h00);
        op("rd5a_after_toggle", 1'b0, 8'h4F, 8'h00);

        // Asynchronous reset mid-cycle; writes ignored while held
        op("wr20", 1'b1, 8'h20, 8'h77);
        op("rd20_77", 1'b0, 8'h20, 8'h00);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_clear", dout, 16'h0000);
        op("wr30_in_reset", 1'b1, 8'h30, 8'h99);
        op("rd30_in_reset", 1'b0, 8'h30, 8'h00);
        #2;
        rst_n = 1'b1;
        op("rd20_cleared", 1'b0, 8'h20, 8'h00);
        op("rd30_ignored", 1'b0, 8'h30, 8'h00);
        op("rdFF_cleared", 1'b0, 8'hFF, 8'h00);

        // Random mix over a narrow window around the wrap point
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra;
            ra = 8'($urandom_range(0, 7)) + 8'hFC;
            op("rand", 1'($urandom_range(0, 1)), ra, 8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter ADDR_W, default 8, address width; depth is 2^ADDR_W bytes (256).
REQ-002 Parameter DATA_W, default 8, byte width; read port width is 2*DATA_W (16).
REQ-003 Port clk, input, 1, single clock; all sequential logic SHALL use its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port rw, input, 1, 1 = write, 0 = read.
REQ-006 Port adrs, input, ADDR_W, byte address for read and write.
REQ-007 Port din, input, DATA_W, write data byte.
REQ-008 Port dout, output, 2*DATA_W, registered read word.

Function
REQ-009 Storage SHALL be 2^ADDR_W locations of DATA_W bits (mem[0..255]).
REQ-010 Write: rising clk with rw=1 SHALL store din into mem[adrs]; no other location changes.
REQ-011 Read: rising clk with rw=0 SHALL load dout with {mem[adrs], mem[adrs+1]}, big-endian: mem[adrs] in dout[15:8] and mem[adrs+1] in dout[7:0].
REQ-012 Read latency SHALL be one cycle; dout changes only on a rising clk edge or on reset.
REQ-013 Address adrs+1 SHALL wrap modulo 2^ADDR_W; reading at adrs=255 returns {mem[255], mem[0]}.
REQ-014 During a write cycle (rw=1), dout SHALL hold its previous value.
REQ-015 A read in the cycle immediately after a write SHALL return the newly written data.
REQ-016 Inputs SHALL be sampled only at the rising clk edge; changes between edges have no effect.
REQ-017 Behaviour SHALL be fully deterministic: no X on dout after reset for any legal input sequence.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for clk, clear dout to 16'h0000 and every mem location to 8'h00.
REQ-019 While rst_n=0, writes and reads SHALL be ignored; dout SHALL stay 16'h0000.
REQ-020 A rst_n assertion mid-operation SHALL discard any in-progress write; the first operation after release SHALL occur on the first rising clk with rst_n=1.
REQ-021 The reset release edge is synchronous to clk by system design; the block adds no synchronizer.

Verification
REQ-022 Reset, then read adrs=0x00, 0x01, 0x03 on consecutive cycles -> dout=16'h0000 one cycle after each read.
REQ-023 Write din=0xFF at adrs=0x03, then read adrs=0x03 -> dout=16'hFF00; read adrs=0x02 -> dout=16'h00FF.
REQ-024 Write 0xAB at 0xFF and 0xCD at 0x00, then read adrs=0xFF -> dout=16'hABCD (wrap-around).
REQ-025 Read adrs=0x10 (dout=X0), then hold rw=1 for 4 cycles writing 0x5A at 0x10 -> dout stays X0 throughout the writes; the next read at 0x10 returns 16'h5A00.
REQ-026 Write 0x77 at 0x20, pulse rst_n low between clk edges -> dout=16'h0000 immediately; after release, reading 0x20 returns 16'h0000.
REQ-027 Toggle adrs/din/rw between edges with no edge present -> no change in dout or memory contents.
